mem_stage_hs: RTL

- Parametrised MEM pipeline stage between EX and WB for the RISC-V core.
- Drives a data-memory port with a req/ready handshake, so memory latency can vary.
- Generates store byte-enables and sign/zero-extends sub-word loads.
- Stalls EX while an access is outstanding; a timeout counter converts a hung access into a bus error.

---
 rtl/mem_stage_hs.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_hs.sv
// ---------------------------------------------------------------------------
// mem_stage_hs -- MEM pipeline stage between EX and WB of the RISC-V core.
//
// Talks to data memory over a req/ready handshake so access latency can vary.
// Builds store byte-enables and lane-replicated store data, sign/zero-extends
// sub-word loads, and back-pressures EX (in_ready low) while an access is
// outstanding. An access that sees no dmem_ready for TIMEOUT_CYCLES cycles is
// retired as a bus error with no register write.
//
// Parameters:
//   XLEN            datapath width, 32 or 64 (NB = XLEN/8 byte lanes)
//   CTRL_WB_W       width of the writeback control bundle
//   RD_W            destination register index width
//   TIMEOUT_CYCLES  max cycles in REQ before a bus error, 2..255
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   flush                     squash the op EX is offering this cycle
//   in_valid / in_ready       EX -> MEM handshake
//   mem_read, mem_write       load / store (both set = store)
//   funct3                    0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
//   ctrl_wb_in, rd_in, pc4_in op fields carried to WB
//   alu_result, store_data    effective address / ALU value, rs2 value
//   dmem_req/we/addr/wdata/be data-memory request (stable while in REQ)
//   dmem_ready, dmem_rdata    completion strobe and read data
//   wb_valid                  one-cycle pulse: WB outputs were updated
//   ctrl_wb_out, rd_wb, pc4_wb, mem_data, alu_data, bus_err  WB outputs
//
// Build option:
//   MEM_MISALIGN_CHK_EN  when defined, misaligned memory ops never reach the
//                        bus and retire as bus errors. When undefined, lanes
//                        past the word boundary are dropped from dmem_be and
//                        load extraction wraps within the word.
// ---------------------------------------------------------------------------
module mem_stage_hs #(
    parameter int XLEN           = 32,
    parameter int CTRL_WB_W      = 3,
    parameter int RD_W           = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [CTRL_WB_W-1:0] ctrl_wb_in,
    input  logic [RD_W-1:0]      rd_in,
    input  logic [XLEN-1:0]      pc4_in,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      store_data,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    output logic [XLEN/8-1:0]    dmem_be,
    input  logic                 dmem_ready,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_valid,
    output logic [CTRL_WB_W-1:0] ctrl_wb_out,
    output logic [RD_W-1:0]      rd_wb,
    output logic [XLEN-1:0]      pc4_wb,
    output logic [XLEN-1:0]      mem_data,
    output logic [XLEN-1:0]      alu_data,
    output logic                 bus_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state;

    // Fields of the outstanding memory op, held while in REQ.
    logic                 lat_is_load;
    logic                 lat_signed;
    logic [1:0]           lat_lg;      // log2 of access size in bytes
    logic [OFFW-1:0]      lat_off;
    logic [CTRL_WB_W-1:0] lat_ctrl;
    logic [RD_W-1:0]      lat_rd;
    logic [XLEN-1:0]      lat_pc4;
    logic [XLEN-1:0]      lat_alu;
    logic [7:0]           tcnt;

    // Decode of the op currently offered by EX.
    logic                 accept;
    logic                 is_mem;
    logic [1:0]           acc_lg;
    logic                 acc_signed;
    logic [OFFW-1:0]      off;
    logic [NB-1:0]        be_next;
    logic [XLEN-1:0]      wdata_next;
    logic [OFFW-1:0]      src_lane;

    // Load extraction from the returned word.
    logic [XLEN-1:0]      load_ext;
    logic [OFFW-1:0]      ld_lane;
    logic [OFFW-1:0]      sign_lane;
    logic                 sign_bit;

    assign in_ready = (state == IDLE);
    assign dmem_req = (state == REQ);
    assign accept   = in_valid && in_ready && !flush;
    assign is_mem   = mem_read || mem_write;
    assign off      = alu_result[OFFW-1:0];

    // Size/sign decode. Codes with no meaning at this XLEN fall back to W.
    // NOTE: every variable written in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        acc_lg     = 2'd2;
        acc_signed = 1'b1;
        case (funct3)
            3'd0: acc_lg = 2'd0;
            3'd1: acc_lg = 2'd1;
            3'd3: if (XLEN == 64) acc_lg = 2'd3;
            3'd4: begin acc_lg = 2'd0; acc_signed = 1'b0; end
            3'd5: begin acc_lg = 2'd1; acc_signed = 1'b0; end
            3'd6: if (XLEN == 64) acc_signed = 1'b0;
            default: ;
        endcase
    end

    // Byte enables cover [off, off+size) and simply stop at the top lane.
    // Store data is the low `size` bytes replicated, rotated so that the
    // first byte sits on lane `off` (a no-op for aligned accesses).
    always_comb begin
        be_next    = '0;
        wdata_next = '0;
        src_lane   = '0;
        for (int i = 0; i < NB; i++) begin
            be_next[i] = (i >= int'(off)) && (i < int'(off) + (1 << acc_lg));
            src_lane   = (OFFW'(i) - off) & OFFW'((1 << acc_lg) - 1);
            wdata_next[8*i +: 8] = store_data[{src_lane, 3'b000} +: 8];
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (off & OFFW'((1 << acc_lg) - 1)) != '0;
`endif

    // Pick `size` bytes starting at lane lat_off (wrapping within the word),
    // then fill the upper bytes with the sign or with zeros.
    always_comb begin
        load_ext = '0;
        ld_lane  = '0;
        for (int k = 0; k < NB; k++) begin
            ld_lane = lat_off + OFFW'(k);
            if (k < (1 << lat_lg)) load_ext[8*k +: 8] = dmem_rdata[{ld_lane, 3'b000} +: 8];
        end
        sign_lane = OFFW'((1 << lat_lg) - 1);
        sign_bit  = lat_signed && load_ext[{sign_lane, 3'b111}];
        for (int k = 0; k < NB; k++) begin
            if (k >= (1 << lat_lg) && sign_bit) load_ext[8*k +: 8] = 8'hFF;
        end
    end

    // NOTE: the reset branch clears every flop, including the wide datapath
    // latches, so no stale address or data is visible after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_is_load <= 1'b0;
            lat_signed  <= 1'b0;
            lat_lg      <= '0;
            lat_off     <= '0;
            lat_ctrl    <= '0;
            lat_rd      <= '0;
            lat_pc4     <= '0;
            lat_alu     <= '0;
            tcnt        <= '0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
            wb_valid    <= 1'b0;
            ctrl_wb_out <= '0;
            rd_wb       <= '0;
            pc4_wb      <= '0;
            mem_data    <= '0;
            alu_data    <= '0;
            bus_err     <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid    <= 1'b1;
                            ctrl_wb_out <= ctrl_wb_in;
                            rd_wb       <= rd_in;
                            pc4_wb      <= pc4_in;
                            alu_data    <= alu_result;
                            mem_data    <= '0;
                            bus_err     <= 1'b0;
                        end
`ifdef MEM_MISALIGN_CHK_EN
                        else if (misaligned) begin
                            wb_valid    <= 1'b1;
                            ctrl_wb_out <= '0;
                            rd_wb       <= rd_in;
                            pc4_wb      <= pc4_in;
                            alu_data    <= alu_result;
                            mem_data    <= '0;
                            bus_err     <= 1'b1;
                        end
`endif
                        else begin
                            state       <= REQ;
                            tcnt        <= '0;
                            lat_is_load <= mem_read && !mem_write;
                            lat_signed  <= acc_signed;
                            lat_lg      <= acc_lg;
                            lat_off     <= off;
                            lat_ctrl    <= ctrl_wb_in;
                            lat_rd      <= rd_in;
                            lat_pc4     <= pc4_in;
                            lat_alu     <= alu_result;
                            dmem_we     <= mem_write;
                            dmem_addr   <= {alu_result[XLEN-1:OFFW], OFFW'(0)};
                            dmem_wdata  <= wdata_next;
                            dmem_be     <= be_next;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        state       <= IDLE;
                        tcnt        <= '0;
                        wb_valid    <= 1'b1;
                        ctrl_wb_out <= lat_ctrl;
                        rd_wb       <= lat_rd;
                        pc4_wb      <= lat_pc4;
                        alu_data    <= lat_alu;
                        mem_data    <= lat_is_load ? load_ext : '0;
                        bus_err     <= 1'b0;
                    end else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Last allowed cycle without ready: retire as a bus
                        // error and suppress the register write.
                        state       <= IDLE;
                        tcnt        <= '0;
                        wb_valid    <= 1'b1;
                        ctrl_wb_out <= '0;
                        rd_wb       <= lat_rd;
                        pc4_wb      <= lat_pc4;
                        alu_data    <= lat_alu;
                        mem_data    <= '0;
                        bus_err     <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
